reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file with a pending-write scoreboard; the next-generation replacement for the fixed 8×8-bit, two-read-port register file in the NoobsCpu datapath. Configurable data width, register count and read-port count; registered read data with one-cycle latency, optional write-to-read forwarding, and synchronous clear. The scoreboard tracks registers with an outstanding write so decode can detect RAW hazards and stall. Sits between decode (reads, reservations) and writeback (writes).

## Interface
- DATA_W, 8, register width in bits
- NUM_REGS, 8, number of registers, power of two, ≥2
- NUM_RD, 2, number of read ports, 1..4
- ADDR_W, $clog2(NUM_REGS), derived localparam, not overridable

- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- rd_en  input  NUM_RD  per-port read enable
- rd_sel  input  NUM_RD*ADDR_W  per-port register select, port p at [p*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
- rd_busy  output  NUM_RD  registered; selected register had a pending write when sampled
- wr_en  input  1  write enable
- wr_sel  input  ADDR_W  write register select
- wr_data  input  DATA_W  write data
- rsv_en  input  1  reserve (mark busy) a register for a future write
- rsv_sel  input  ADDR_W  register to reserve
- busy_vec  output  NUM_REGS  current scoreboard state, direct from flops

## Operation
- Reset (reset=1 at a clock edge): all registers ← 0, busy_vec ← 0, rd_data ← 0, rd_busy ← 0. Overrides any same-cycle write, reservation or read; a reservation or write in flight at reset is discarded.
- Write: wr_en=1 → reg[wr_sel] ← wr_data at edge; busy[wr_sel] ← 0.
- Reserve: rsv_en=1 → busy[rsv_sel] ← 1 at edge.
- Same edge, rsv_sel == wr_sel, both enabled: busy ends 1 (new reservation wins); data still written.
- Read port p, rd_en[p]=1: rd_data[p] ← reg[rd_sel[p]], rd_busy[p] ← busy[rd_sel[p]] at edge. With forwarding (see Configuration) and wr_en=1, wr_sel==rd_sel[p]: rd_data[p] ← wr_data, rd_busy[p] ← 0 unless rsv_en with rsv_sel==rd_sel[p] same cycle (then 1).
- rd_en[p]=0: rd_data[p] ← 0, rd_busy[p] ← 0.
- Ports independent; any number may select the same register.
- Write to non-busy register is legal; busy stays 0.
- No wrap/overflow arithmetic; selects are always in range since NUM_REGS is a power of two.

## Timing
- Read latency 1 cycle: selects at edge N → rd_data/rd_busy valid after edge N, held until edge N+1.
- Write visible to a read sampled at the following edge (N+1) without forwarding; at the same edge (N) with forwarding.
- busy_vec reflects reservations/writes one edge after request; reservation at edge N and read of same register at edge N+1 → rd_busy=1.
- No handshake; all inputs sampled every cycle. No stall generation inside the block; consumer uses rd_busy.

## Configuration
- REG_FILE_MP_BYPASS_EN defined: same-cycle write-to-read forwarding of data and busy as above (predecessor-compatible RAW avoidance).
- Undefined: read returns pre-write register contents and pre-write busy bit; write appears from next read onward. Removes NUM_RD comparators from read path.

## Structure
- Shared package noobs_pkg: default DATA_W, NUM_REGS, NUM_RD constants; reg_idx_t (ADDR_W-bit) and reg_data_t (DATA_W-bit) typedefs.
- One sub-module: reg_file_scoreboard (busy_vec flops, set/clear priority, per-port busy lookup incl. forwarding); storage array and read muxes stay in top.

## Test plan
- Reset then read all: reset 1 cycle, rd_en=all ones, rd_sel=0..NUM_RD-1 → rd_data all 0x00, rd_busy 0, busy_vec 0.
- Write/readback: write 0xA5 to r3, next cycle read r3 on port 0 and r3 on port 1 → both 0xA5 one cycle later.
- Same-cycle RAW: write 0x3C to r5 while reading r5 → with macro 0x3C, rd_busy 0; without macro old value (0x00 after reset).
- Scoreboard: reserve r2; next cycle read r2 → rd_busy=1, busy_vec=0x04; write 0x11 to r2 → busy_vec=0x00, next read 0x11, rd_busy 0.
- Reserve+write collision: rsv_en and wr_en both r6, wr_data 0x77 → busy_vec[6]=1, reg6=0x77.
- Reset mid-operation: r1=0x55 reserved, reset asserted with wr_en to r1=0x99 → r1=0x00, busy_vec=0, rd_data 0; rd_en=0 afterwards → rd_data 0. Repeat with DATA_W=16, NUM_REGS=16, NUM_RD=3.

Source files
------------

// File: rtl/noobs_pkg.sv
// Shared NoobsCpu datapath constants and register-file index/data types.
package noobs_pkg;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: busy flops, set/clear priority and per-port busy lookup.
// REG_FILE_MP_BYPASS_EN forwards a same-cycle write's busy clear to the read ports.
module reg_file_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_sel,
    input  logic                           rsv_en,
    input  logic [ADDR_W-1:0]              rsv_sel,
    input  logic [NUM_RD-1:0]              rd_en,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_sel,
    output logic [NUM_REGS-1:0]            busy_vec,
    output logic [NUM_RD-1:0]              rd_busy
);
    logic [NUM_RD-1:0] busy_lk;

    always_comb begin
        busy_lk = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            busy_lk[p] = busy_vec[rd_sel[p]];
`ifdef REG_FILE_MP_BYPASS_EN
            if (wr_en && (wr_sel == rd_sel[p]))
                busy_lk[p] = rsv_en && (rsv_sel == rd_sel[p]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_vec <= '0;
            rd_busy  <= '0;
        end else begin
            // Reservation is assigned last so it wins over a same-register write clear.
            if (wr_en)
                busy_vec[wr_sel] <= 1'b0;
            if (rsv_en)
                busy_vec[rsv_sel] <= 1'b1;
            for (int p = 0; p < NUM_RD; p++)
                rd_busy[p] <= rd_en[p] & busy_lk[p];
        end
    end
endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with registered reads and a pending-write scoreboard.
// Define REG_FILE_MP_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_mp
    import noobs_pkg::*;
#(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  NUM_REGS = DEF_NUM_REGS,
    parameter int  NUM_RD   = DEF_NUM_RD,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_sel,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_sel,
    output logic [NUM_REGS-1:0]      busy_vec
);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_RD-1:0][ADDR_W-1:0]   rd_sel_a;
    logic [NUM_RD-1:0][DATA_W-1:0]   rd_word;
    logic [NUM_RD-1:0][DATA_W-1:0]   rd_data_q;

    assign rd_sel_a = rd_sel;
    assign rd_data  = rd_data_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
`ifdef REG_FILE_MP_BYPASS_EN
        assign rd_word[p] = (wr_en && (wr_sel == rd_sel_a[p])) ? wr_data : regs[rd_sel_a[p]];
`else
        assign rd_word[p] = regs[rd_sel_a[p]];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs      <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_en)
                regs[wr_sel] <= wr_data;
            for (int p = 0; p < NUM_RD; p++)
                rd_data_q[p] <= rd_en[p] ? rd_word[p] : '0;
        end
    end

    reg_file_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .rsv_en   (rsv_en),
        .rsv_sel  (rsv_sel),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel_a),
        .busy_vec (busy_vec),
        .rd_busy  (rd_busy)
    );
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp: default 8x8x2 instance plus a 16x16x3 instance.
module tb_reg_file_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // default configuration
    logic        reset;
    logic [1:0]  rd_en;
    logic [5:0]  rd_sel;
    logic [15:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [7:0]  wr_data;
    logic        rsv_en;
    logic [2:0]  rsv_sel;
    logic [7:0]  busy_vec;

    // wide configuration
    logic        reset_b;
    logic [2:0]  rd_en_b;
    logic [11:0] rd_sel_b;
    logic [47:0] rd_data_b;
    logic [2:0]  rd_busy_b;
    logic        wr_en_b;
    logic [3:0]  wr_sel_b;
    logic [15:0] wr_data_b;
    logic        rsv_en_b;
    logic [3:0]  rsv_sel_b;
    logic [15:0] busy_vec_b;

    reg_file_mp dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel), .busy_vec(busy_vec)
    );

    reg_file_mp #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(3)) dut_b (
        .clk(clk), .reset(reset_b), .rd_en(rd_en_b), .rd_sel(rd_sel_b), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en_b), .wr_sel(wr_sel_b), .wr_data(wr_data_b),
        .rsv_en(rsv_en_b), .rsv_sel(rsv_sel_b), .busy_vec(busy_vec_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        reset = 0; rd_en = 0; rd_sel = 0; wr_en = 0; wr_sel = 0; wr_data = 0;
        rsv_en = 0; rsv_sel = 0;
    endtask

    task automatic idle_b();
        reset_b = 0; rd_en_b = 0; rd_sel_b = 0; wr_en_b = 0; wr_sel_b = 0; wr_data_b = 0;
        rsv_en_b = 0; rsv_sel_b = 0;
    endtask

    initial begin
        idle_a(); idle_b();
        // reset, then read r0/r1
        reset = 1; reset_b = 1; rd_en = 2'b11; rd_sel = {3'd1, 3'd0};
        tick();
        check("rst_data", 64'(rd_data), 64'h0);
        check("rst_busy", 64'(rd_busy), 64'h0);
        check("rst_bvec", 64'(busy_vec), 64'h0);
        check("rst_bvec_b", 64'(busy_vec_b), 64'h0);
        reset = 0; reset_b = 0;
        tick();
        check("rd_all_zero", 64'(rd_data), 64'h0);

        // write/readback r3
        idle_a(); wr_en = 1; wr_sel = 3; wr_data = 8'hA5;
        tick();
        check("wr_rden0", 64'(rd_data), 64'h0);
        idle_a(); rd_en = 2'b11; rd_sel = {3'd3, 3'd3};
        tick();
        check("rb_r3", 64'(rd_data), 64'hA5A5);
        check("rb_r3_busy", 64'(rd_busy), 64'h0);

        // same-cycle RAW on r5, port 0 only
        idle_a(); wr_en = 1; wr_sel = 5; wr_data = 8'h3C; rd_en = 2'b01; rd_sel = {3'd0, 3'd5};
        tick();
`ifdef REG_FILE_MP_BYPASS_EN
        check("raw_r5", 64'(rd_data), 64'h003C);
`else
        check("raw_r5", 64'(rd_data), 64'h0000);
`endif
        check("raw_busy", 64'(rd_busy), 64'h0);
        idle_a(); rd_en = 2'b01; rd_sel = {3'd0, 3'd5};
        tick();
        check("raw_r5_next", 64'(rd_data), 64'h003C);

        // scoreboard on r2
        idle_a(); rsv_en = 1; rsv_sel = 2;
        tick();
        check("rsv_bvec", 64'(busy_vec), 64'h04);
        idle_a(); rd_en = 2'b11; rd_sel = {3'd2, 3'd2};
        tick();
        check("rsv_rdbusy", 64'(rd_busy), 64'h3);
        check("rsv_bvec_hold", 64'(busy_vec), 64'h04);
        idle_a(); wr_en = 1; wr_sel = 2; wr_data = 8'h11;
        tick();
        check("wr_clr_bvec", 64'(busy_vec), 64'h00);
        check("rden0_busy", 64'(rd_busy), 64'h0);
        idle_a(); rd_en = 2'b10; rd_sel = {3'd2, 3'd0};
        tick();
        check("r2_data", 64'(rd_data), 64'h1100);
        check("r2_busy", 64'(rd_busy), 64'h0);

        // reserve + write collision on r6
        idle_a(); rsv_en = 1; rsv_sel = 6; wr_en = 1; wr_sel = 6; wr_data = 8'h77;
        tick();
        check("coll_bvec", 64'(busy_vec), 64'h40);
        idle_a(); rd_en = 2'b01; rd_sel = {3'd0, 3'd6};
        tick();
        check("coll_data", 64'(rd_data), 64'h0077);
        check("coll_busy", 64'(rd_busy), 64'h1);

        // reset mid-operation: r1=0x55 reserved, reset with write of 0x99
        idle_a(); wr_en = 1; wr_sel = 1; wr_data = 8'h55;
        tick();
        idle_a(); rsv_en = 1; rsv_sel = 1;
        tick();
        check("pre_rst_bvec", 64'(busy_vec), 64'h42);
        idle_a(); reset = 1; wr_en = 1; wr_sel = 1; wr_data = 8'h99; rsv_en = 1; rsv_sel = 3;
        rd_en = 2'b11; rd_sel = {3'd1, 3'd6};
        tick();
        check("mid_rst_data", 64'(rd_data), 64'h0);
        check("mid_rst_busy", 64'(rd_busy), 64'h0);
        check("mid_rst_bvec", 64'(busy_vec), 64'h0);
        idle_a();
        tick();
        check("post_rst_rden0", 64'(rd_data), 64'h0);
        idle_a(); rd_en = 2'b11; rd_sel = {3'd3, 3'd1};
        tick();
        check("post_rst_r1_r3", 64'(rd_data), 64'h0);
        check("post_rst_busy", 64'(rd_busy), 64'h0);

        // wide configuration: write r9, then reserve while reading
        idle_b(); wr_en_b = 1; wr_sel_b = 9; wr_data_b = 16'hBEEF;
        tick();
        idle_b(); rsv_en_b = 1; rsv_sel_b = 9; rd_en_b = 3'b111; rd_sel_b = {4'd9, 4'd9, 4'd0};
        tick();
        check("b_rd", 64'(rd_data_b), 64'hBEEF_BEEF_0000);
        check("b_rd_busy", 64'(rd_busy_b), 64'h0);
        check("b_bvec", 64'(busy_vec_b), 64'h0200);
        idle_b(); rd_en_b = 3'b100; rd_sel_b = {4'd9, 4'd0, 4'd0};
        tick();
        check("b_busy_p2", 64'(rd_busy_b), 64'h4);
        idle_b(); reset_b = 1; wr_en_b = 1; wr_sel_b = 9; wr_data_b = 16'h1234;
        rd_en_b = 3'b111; rd_sel_b = {4'd9, 4'd9, 4'd9};
        tick();
        check("b_rst_data", 64'(rd_data_b), 64'h0);
        check("b_rst_bvec", 64'(busy_vec_b), 64'h0);
        check("b_rst_busy", 64'(rd_busy_b), 64'h0);
        idle_b();
        tick();
        check("b_rden0", 64'(rd_data_b), 64'h0);
        idle_b(); rd_en_b = 3'b100; rd_sel_b = {4'd9, 4'd0, 4'd0};
        tick();
        check("b_r9_cleared", 64'(rd_data_b), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
